// File: rtl/alu_seq_if.sv
// Request/result bus between the LEGv8 control unit (master) and the registered EX-stage ALU (slave).
interface alu_seq_if #(parameter int N = 64);
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  a;
   logic [N-1:0]  b;
   logic [4:0]    ALUc;
   logic          out_valid;
   logic [N-1:0]  result;
   logic          zero;
   logic [3:0]    CPSR_flags;
   logic          write_flags;

   modport master (
      output in_valid, a, b, ALUc,
      input  in_ready, out_valid, result, zero, CPSR_flags, write_flags
   );

   modport slave (
      input  in_valid, a, b, ALUc,
      output in_ready, out_valid, result, zero, CPSR_flags, write_flags
   );
endinterface

// File: rtl/alu_seq.sv
// Registered EX-stage ALU with valid/ready request, persistent {Z,N,C,V} flag register and,
// when ALU_MUL_EN is defined, an N-iteration shift-add multiplier (opcode 1000).
module alu_seq #(
   parameter int N = 64
) (
   input logic       clk,
   input logic       reset,
   alu_seq_if.slave  bus
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_EOR  = 4'b0011;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_PASS = 4'b0111;
`ifdef ALU_MUL_EN
   localparam logic [3:0] OP_MUL  = 4'b1000;
   localparam int         CW      = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);
`endif
   localparam logic [N:0] ONE = {{N{1'b0}}, 1'b1};

   logic [N-1:0] result_q;
   logic         zero_q;
   logic         out_valid_q;
   logic         write_flags_q;
   logic [3:0]   flags_q;
   logic         accept;

   logic [N:0]   add_sum;
   logic [N:0]   sub_sum;
   logic [N-1:0] op_res;
   logic         op_c;
   logic         op_v;
   logic         op_legal;

`ifdef ALU_MUL_EN
   typedef enum logic {IDLE, MUL} state_t;

   state_t        state;
   logic          ready_q;
   logic [CW-1:0] iter;
   logic [N-1:0]  mcand;
   logic [N-1:0]  mplier;
   logic [N-1:0]  acc;
   logic [N-1:0]  acc_next;
   logic          mul_set;
   logic          op_is_mul;

   assign acc_next     = mplier[0] ? acc + mcand : acc;
   assign bus.in_ready = ready_q;
`else
   assign bus.in_ready = 1'b1;
`endif

   assign accept  = bus.in_valid && bus.in_ready;
   assign add_sum = {1'b0, bus.a} + {1'b0, bus.b};
   assign sub_sum = {1'b0, bus.a} + {1'b0, ~bus.b} + ONE;

   // Single-cycle operations, evaluated on the operands presented at the accepting edge.
   always_comb begin
      op_res   = '0;
      op_c     = 1'b0;
      op_v     = 1'b0;
      op_legal = 1'b1;
`ifdef ALU_MUL_EN
      op_is_mul = 1'b0;
`endif
      case (bus.ALUc[3:0])
         OP_AND:  op_res = bus.a & bus.b;
         OP_OR:   op_res = bus.a | bus.b;
         OP_EOR:  op_res = bus.a ^ bus.b;
         OP_PASS: op_res = bus.b;
         OP_ADD: begin
            op_res = add_sum[N-1:0];
            op_c   = add_sum[N];
            op_v   = (bus.a[N-1] == bus.b[N-1]) && (add_sum[N-1] != bus.a[N-1]);
         end
         OP_SUB: begin
            op_res = sub_sum[N-1:0];
            op_c   = sub_sum[N];
            op_v   = (bus.a[N-1] != bus.b[N-1]) && (sub_sum[N-1] != bus.a[N-1]);
         end
`ifdef ALU_MUL_EN
         OP_MUL:  op_is_mul = 1'b1;
`endif
         default: op_legal = 1'b0;
      endcase
   end

   // Control FSM and all registered outputs; an illegal opcode still completes, with result 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         result_q      <= '0;
         zero_q        <= 1'b0;
         out_valid_q   <= 1'b0;
         write_flags_q <= 1'b0;
         flags_q       <= 4'b0000;
`ifdef ALU_MUL_EN
         state         <= IDLE;
         ready_q       <= 1'b1;
         iter          <= '0;
         mcand         <= '0;
         mplier        <= '0;
         acc           <= '0;
         mul_set       <= 1'b0;
`endif
      end else begin
         out_valid_q   <= 1'b0;
         write_flags_q <= 1'b0;
`ifdef ALU_MUL_EN
         if (state == MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            iter   <= iter + CW'(1);
            if (iter == LAST) begin
               state       <= IDLE;
               ready_q     <= 1'b1;
               result_q    <= acc_next;
               zero_q      <= (acc_next == '0);
               out_valid_q <= 1'b1;
               if (mul_set) begin
                  flags_q       <= {(acc_next == '0), acc_next[N-1], 2'b00};
                  write_flags_q <= 1'b1;
               end
            end
         end else if (accept && op_is_mul) begin
            state   <= MUL;
            ready_q <= 1'b0;
            iter    <= '0;
            mcand   <= bus.a;
            mplier  <= bus.b;
            acc     <= '0;
            mul_set <= bus.ALUc[4];
         end else
`endif
         if (accept) begin
            result_q    <= op_res;
            zero_q      <= (op_res == '0);
            out_valid_q <= 1'b1;
            if (op_legal && bus.ALUc[4]) begin
               flags_q       <= {(op_res == '0), op_res[N-1], op_c, op_v};
               write_flags_q <= 1'b1;
            end
         end
      end
   end

   assign bus.result      = result_q;
   assign bus.zero        = zero_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.write_flags = write_flags_q;
   assign bus.CPSR_flags  = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: vector table driven through a scoreboard, plus hand-written
// multiplier-busy and reset-abort sequences (the MUL parts apply when ALU_MUL_EN is defined).
module tb_alu_seq;

   localparam int N = 64;
`ifdef ALU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   typedef struct {
      string        name;
      logic [4:0]   aluc;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [N-1:0] res;
      logic         zero;
      logic         wf;
      logic [3:0]   flags;
   } vec_t;

   typedef struct {
      string        name;
      logic [N-1:0] res;
      logic         zero;
      logic         wf;
      logic [3:0]   flags;
      int           due;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   passes = 0;
   vec_t tbl[$];
   exp_t sb[$];

   alu_seq_if #(.N(N)) bus();

   alu_seq #(.N(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, required $finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act === req) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
   endtask

   function automatic vec_t mkVec(input string n, input logic [4:0] c, input logic [N-1:0] a,
                                  input logic [N-1:0] b, input logic [N-1:0] r, input logic z,
                                  input logic w, input logic [3:0] f);
      vec_t v;
      v.name = n; v.aluc = c; v.a = a; v.b = b;
      v.res = r; v.zero = z; v.wf = w; v.flags = f;
      return v;
   endfunction

   // Drive one request; push its expectation when the DUT will take it at the next edge.
   task automatic applyStimulus(input vec_t v);
      exp_t e;
      int   guard = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = v.a;
      bus.b        = v.b;
      bus.ALUc     = v.aluc;
      while (bus.in_ready !== 1'b1 && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (bus.in_ready !== 1'b1) begin
         checkOutput({v.name, "_ready_timeout"}, 64'(bus.in_ready), 64'd1);
         bus.in_valid = 1'b0;
         return;
      end
      e.name  = v.name;
      e.res   = v.res;
      e.zero  = v.zero;
      e.wf    = v.wf;
      e.flags = v.flags;
      e.due   = cyc + ((MUL_EN && v.aluc[3:0] == 4'b1000) ? N + 1 : 1);
      sb.push_back(e);
      @(posedge clk);
   endtask

   task automatic idleBus();
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic waitDrain();
      int g = 0;
      while (sb.size() != 0 && g < 500) begin
         @(negedge clk);
         g++;
      end
   endtask

   // Output side of the scoreboard.
   always @(negedge clk) begin
      if (bus.out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            $display("[TB] FAIL unexpected_out_valid: got out_valid=1 result=0x%0h, required no pending op",
                     bus.result);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput({e.name, "_result"}, 64'(bus.result), 64'(e.res));
            checkOutput({e.name, "_zero"}, 64'(bus.zero), 64'(e.zero));
            checkOutput({e.name, "_write_flags"}, 64'(bus.write_flags), 64'(e.wf));
            checkOutput({e.name, "_flags"}, 64'(bus.CPSR_flags), 64'(e.flags));
            checkOutput({e.name, "_latency_cycle"}, 64'(cyc), 64'(e.due));
         end
      end
   end

   initial begin
      int busy;
      int guard;

      reset        = 1'b1;
      bus.in_valid = 1'b1;
      bus.ALUc     = 5'b10010;
      bus.a        = 64'd1;
      bus.b        = 64'd1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      checkOutput("rst_result", 64'(bus.result), 64'd0);
      checkOutput("rst_zero", 64'(bus.zero), 64'd0);
      checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("rst_write_flags", 64'(bus.write_flags), 64'd0);
      checkOutput("rst_flags", 64'(bus.CPSR_flags), 64'd0);
      checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
      repeat (2) @(negedge clk);

      tbl.push_back(mkVec("ADDS_ovf",   5'b10010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
                          64'h8000_0000_0000_0000, 1'b0, 1'b1, 4'b0101));
      tbl.push_back(mkVec("SUBS_eq",    5'b10110, 64'd5, 64'd5, 64'd0, 1'b1, 1'b1, 4'b1010));
      tbl.push_back(mkVec("SUB_noS",    5'b00110, 64'd3, 64'd5,
                          64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 4'b1010));
      tbl.push_back(mkVec("AND",        5'b00000, 64'hF0, 64'h3C, 64'h30, 1'b0, 1'b0, 4'b1010));
      tbl.push_back(mkVec("OR",         5'b00001, 64'hF0, 64'h0F, 64'hFF, 1'b0, 1'b0, 4'b1010));
      tbl.push_back(mkVec("PASS",       5'b00111, 64'h1234, 64'h55, 64'h55, 1'b0, 1'b0, 4'b1010));
      tbl.push_back(mkVec("EORS",       5'b10011, 64'hFF00, 64'h0FF0, 64'hF0F0, 1'b0, 1'b1, 4'b0000));
      tbl.push_back(mkVec("ADDS_carry", 5'b10010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                          64'd0, 1'b1, 1'b1, 4'b1010));
      tbl.push_back(mkVec("SUBS_borrow",5'b10110, 64'd3, 64'd5,
                          64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 4'b0100));
      tbl.push_back(mkVec("SUBS_ovf",   5'b10110, 64'h8000_0000_0000_0000, 64'd1,
                          64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 4'b0011));
      tbl.push_back(mkVec("ANDS_neg",   5'b10000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                          64'h8000_0000_0000_0000, 1'b0, 1'b1, 4'b0100));
      tbl.push_back(mkVec("ILLEGAL",    5'b11111, 64'd1, 64'd2, 64'd0, 1'b1, 1'b0, 4'b0100));
      tbl.push_back(mkVec("ADDS_negovf",5'b10010, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                          64'd0, 1'b1, 1'b1, 4'b1011));
`ifdef ALU_MUL_EN
      tbl.push_back(mkVec("MULS_7x6",   5'b11000, 64'd7, 64'd6, 64'd42, 1'b0, 1'b1, 4'b0000));
`else
      tbl.push_back(mkVec("MUL_disabled",5'b11000, 64'd7, 64'd6, 64'd0, 1'b1, 1'b0, 4'b1011));
`endif

      foreach (tbl[i]) applyStimulus(tbl[i]);
      idleBus();
      waitDrain();

`ifdef ALU_MUL_EN
      // Multiplier busy window: a request held during MUL must be ignored.
      applyStimulus(mkVec("MUL_12345x678", 5'b01000, 64'd12345, 64'd678,
                          64'd8369910, 1'b0, 1'b0, 4'b0000));
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.ALUc     = 5'b10010;
      bus.a        = 64'd9;
      bus.b        = 64'd9;
      busy  = 0;
      guard = 0;
      while (bus.in_ready === 1'b0 && guard < 1000) begin
         busy++;
         @(negedge clk);
         guard++;
      end
      bus.in_valid = 1'b0;
      checkOutput("mul_busy_cycles", 64'(busy), 64'(N));
      waitDrain();
`endif

      applyStimulus(mkVec("SUBS_pre_rst", 5'b10110, 64'd5, 64'd5, 64'd0, 1'b1, 1'b1, 4'b1010));
      idleBus();
      waitDrain();

`ifdef ALU_MUL_EN
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.ALUc     = 5'b11000;
      bus.a        = 64'd99;
      bus.b        = 64'd77;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (9) @(negedge clk);
`endif
      // Reset with a simultaneous request: reset wins, the request is dropped.
      reset        = 1'b1;
      bus.in_valid = 1'b1;
      bus.ALUc     = 5'b10010;
      bus.a        = 64'd7;
      bus.b        = 64'd9;
      @(negedge clk);
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      checkOutput("abort_flags", 64'(bus.CPSR_flags), 64'd0);
      checkOutput("abort_in_ready", 64'(bus.in_ready), 64'd1);
      checkOutput("abort_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("abort_write_flags", 64'(bus.write_flags), 64'd0);

      applyStimulus(mkVec("ADD_after_rst", 5'b00010, 64'd2, 64'd3, 64'd5, 1'b0, 1'b0, 4'b0000));
      idleBus();
      waitDrain();
      repeat (4) @(negedge clk);
      checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
